// File: rtl/ppu_update_seq_pkg.sv
// Shared definitions for the PPU shadow-table update sequencer: state
// encoding, write-target codes and table entry widths.
package ppu_update_seq_pkg;

  localparam int SPR_W  = 30;
  localparam int STAT_W = 22;
  localparam int OFF_W  = 12;

  typedef enum logic [1:0] {
    ST_OPEN = 2'd0,
    ST_PEND = 2'd1,
    ST_UPD  = 2'd2,
    ST_ACK  = 2'd3
  } seq_state_t;

  localparam logic [1:0] SEL_SPR  = 2'b00;
  localparam logic [1:0] SEL_STAT = 2'b01;
  localparam logic [1:0] SEL_OFF  = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  // True when a write targets an entry that really exists.
  function automatic logic wr_in_range(input logic [1:0] sel, input logic [2:0] idx,
                                       input int nspr, input int nstat);
    case (sel)
      SEL_SPR:  return int'(idx) < nspr;
      SEL_STAT: return int'(idx) < nstat;
      SEL_OFF:  return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ppu_update_seq_edge_det.sv
// Registered edge detector: flags the cycle in which the input first shows
// its active level (POL) after having been inactive on the previous edge.
module ppu_edge_det #(
  parameter logic POL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic hist_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) hist_q <= ~POL;
    else        hist_q <= sig;
  end

  assign rise = (sig == POL) && (hist_q != POL);

endmodule

// File: rtl/ppu_update_seq.sv
// Double-buffered sprite/static/offset tables presented to the PPU on vsync.
// Optional PEND watchdog enabled by defining PPU_SEQ_WATCHDOG_EN.
module ppu_update_seq
  import ppu_update_seq_pkg::*;
#(
  parameter int NSPR      = 6,
  parameter int NSTAT     = 6,
  parameter int VSYNC_POL = 0,
  parameter int WD_CYCLES = 2000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    vsync,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [1:0]              wr_sel,
  input  logic [2:0]              wr_idx,
  input  logic [SPR_W-1:0]        wr_data,
  input  logic                    commit_req,
  output logic                    commit_ack,
  output logic [SPR_W*NSPR-1:0]   sprites,
  output logic [STAT_W*NSTAT-1:0] statics,
  output logic [OFF_W-1:0]        offset_x,
  output logic [OFF_W-1:0]        offset_y,
  output logic                    update,
  output logic [7:0]              frame_cnt,
  output logic                    err
);

  seq_state_t        state_q;
  logic [7:0]        frame_q;
  logic              err_q;
  logic              vs_rise;
  logic              wd_fire;
  logic              wr_fire;
  logic [SPR_W-1:0]  spr_q  [NSPR];
  logic [STAT_W-1:0] stat_q [NSTAT];
  logic [OFF_W-1:0]  offx_q;
  logic [OFF_W-1:0]  offy_q;

  ppu_edge_det #(.POL(VSYNC_POL != 0)) u_vsync_edge (
    .clock (clock),
    .reset (reset),
    .sig   (vsync),
    .rise  (vs_rise)
  );

`ifdef PPU_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  wd_cnt_q <= '0;
    else if (state_q == ST_PEND) wd_cnt_q <= wd_fire ? '0 : wd_cnt_q + 1'b1;
    else                         wd_cnt_q <= '0;
  end

  assign wd_fire = (state_q == ST_PEND) && (wd_cnt_q == WD_W'(WD_CYCLES - 1));
`else
  assign wd_fire = 1'b0;
`endif

  // Sequencer: an edge only counts once the commit is already pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OPEN;
      frame_q <= '0;
    end else begin
      case (state_q)
        ST_OPEN: if (commit_req) state_q <= ST_PEND;
        ST_PEND: if (vs_rise || wd_fire) state_q <= ST_UPD;
        ST_UPD: begin
          state_q <= ST_ACK;
          frame_q <= frame_q + 8'd1;
        end
        default: state_q <= ST_OPEN;
      endcase
    end
  end

  assign wr_ready   = (state_q == ST_OPEN);
  assign update     = (state_q == ST_UPD);
  assign commit_ack = (state_q == ST_ACK);
  assign frame_cnt  = frame_q;
  assign wr_fire    = wr_valid && wr_ready;

  // Shadow tables only change while the sequencer is open.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSPR; i++)  spr_q[i]  <= '0;
      for (int i = 0; i < NSTAT; i++) stat_q[i] <= '0;
      offx_q <= '0;
      offy_q <= '0;
      err_q  <= 1'b0;
    end else if (wr_fire) begin
      if (!wr_in_range(wr_sel, wr_idx, NSPR, NSTAT)) begin
        err_q <= 1'b1;
      end else begin
        case (wr_sel)
          SEL_SPR:  spr_q[wr_idx]  <= wr_data;
          SEL_STAT: stat_q[wr_idx] <= wr_data[STAT_W-1:0];
          default: begin
            offx_q <= wr_data[OFF_W-1:0];
            offy_q <= wr_data[2*OFF_W-1:OFF_W];
          end
        endcase
      end
    end
  end

  always_comb begin
    sprites = '0;
    statics = '0;
    for (int i = 0; i < NSPR; i++)  sprites[i*SPR_W +: SPR_W]   = spr_q[i];
    for (int i = 0; i < NSTAT; i++) statics[i*STAT_W +: STAT_W] = stat_q[i];
  end

  assign offset_x = offx_q;
  assign offset_y = offy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ppu_update_seq.sv
// Self-checking bench for ppu_update_seq against a table-level reference model.
module tb_ppu_update_seq;

  localparam int NSPR  = 6;
  localparam int NSTAT = 6;

  logic                clock = 1'b0;
  logic                reset;
  logic                vsync;
  logic                wr_valid;
  logic                wr_ready;
  logic [1:0]          wr_sel;
  logic [2:0]          wr_idx;
  logic [29:0]         wr_data;
  logic                commit_req;
  logic                commit_ack;
  logic [30*NSPR-1:0]  sprites;
  logic [22*NSTAT-1:0] statics;
  logic [11:0]         offset_x;
  logic [11:0]         offset_y;
  logic                update;
  logic [7:0]          frame_cnt;
  logic                err;

  int passed = 0;
  int total  = 0;

  logic [29:0] m_spr  [NSPR];
  logic [21:0] m_stat [NSTAT];
  logic [11:0] m_ox, m_oy;
  logic        m_err;
  int          m_frames;

  ppu_update_seq #(.NSPR(NSPR), .NSTAT(NSTAT), .VSYNC_POL(0), .WD_CYCLES(50)) dut (
    .clock(clock), .reset(reset), .vsync(vsync), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data), .commit_req(commit_req),
    .commit_ack(commit_ack), .sprites(sprites), .statics(statics), .offset_x(offset_x),
    .offset_y(offset_y), .update(update), .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  function automatic void model_clear();
    for (int i = 0; i < NSPR; i++)  m_spr[i]  = '0;
    for (int i = 0; i < NSTAT; i++) m_stat[i] = '0;
    m_ox = '0; m_oy = '0; m_err = 1'b0; m_frames = 0;
  endfunction

  function automatic void model_write(input logic [1:0] sel, input int idx, input logic [29:0] d);
    case (sel)
      2'b00: if (idx < NSPR) m_spr[idx] = d; else m_err = 1'b1;
      2'b01: if (idx < NSTAT) m_stat[idx] = d[21:0]; else m_err = 1'b1;
      2'b10: begin m_ox = d[11:0]; m_oy = d[23:12]; end
      default: m_err = 1'b1;
    endcase
  endfunction

  function automatic logic [30*NSPR-1:0] exp_spr();
    logic [30*NSPR-1:0] v;
    for (int i = 0; i < NSPR; i++) v[30*i +: 30] = m_spr[i];
    return v;
  endfunction

  function automatic logic [22*NSTAT-1:0] exp_stat();
    logic [22*NSTAT-1:0] v;
    for (int i = 0; i < NSTAT; i++) v[22*i +: 22] = m_stat[i];
    return v;
  endfunction

  // Called at a negedge while the sequencer is open; returns at the next negedge.
  task automatic do_write(input logic [1:0] sel, input logic [2:0] idx, input logic [29:0] d);
    wr_valid = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = d;
    @(negedge clock);
    wr_valid = 1'b0;
    model_write(sel, int'(idx), d);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr_valid = 1'b1; wr_sel = 2'b00; wr_idx = 3'd1; wr_data = 30'h3ABCDEF1;
    repeat (3) @(negedge clock);
    model_clear();
    total++;
    if ({update, commit_ack, frame_cnt, err} !== 11'd0) $display("FAIL reset_ctrl: got %h want 0", {update, commit_ack, frame_cnt, err});
    else passed++;
    total++;
    if ({sprites, statics, offset_x, offset_y} !== '0) $display("FAIL reset_shadow: got %h want 0", {sprites, statics});
    else passed++;
    total++;
    if (wr_ready !== 1'b1) $display("FAIL reset_open: wr_ready got %b want 1", wr_ready);
    else passed++;
    wr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_sprite_write();
    do_write(2'b00, 3'd2, 30'h12345678);
    total++;
    if (sprites[89:60] !== 30'h12345678) $display("FAIL spr2_entry: got %h want %h", sprites[89:60], 30'h12345678);
    else passed++;
    total++;
    if (sprites !== exp_spr()) $display("FAIL spr2_bus: got %h want %h", sprites, exp_spr());
    else passed++;
  endtask

  task automatic test_random_writes();
    for (int k = 0; k < 40; k++) begin
      logic [1:0] s;
      s = 2'($urandom_range(0, 2));
      do_write(s, 3'($urandom_range(0, 5)), 30'($urandom));
      total++;
      if ({sprites, statics, offset_y, offset_x, err} !== {exp_spr(), exp_stat(), m_oy, m_ox, m_err})
        $display("FAIL rand_write_%0d: got spr %h stat %h oy %h ox %h err %b want spr %h stat %h oy %h ox %h err %b",
                 k, sprites, statics, offset_y, offset_x, err, exp_spr(), exp_stat(), m_oy, m_ox, m_err);
      else passed++;
    end
  endtask

  task automatic test_commit_latency();
    int bad;
    commit_req = 1'b1;
    @(negedge clock);
    commit_req = 1'b0;
    total++;
    if (wr_ready !== 1'b0) $display("FAIL pend_ready: got %b want 0", wr_ready);
    else passed++;
    bad = 0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clock);
      if (update !== 1'b0 || commit_ack !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL pend_idle: early strobes %0d want 0", bad);
    else passed++;
    vsync = 1'b0;
    @(negedge clock);
    total++;
    if ({update, commit_ack} !== 2'b10) $display("FAIL lat_update: got upd/ack %b want 10", {update, commit_ack});
    else passed++;
    vsync = 1'b1;
    @(negedge clock);
    m_frames = (m_frames + 1) % 256;
    total++;
    if ({update, commit_ack, frame_cnt} !== {2'b01, 8'(m_frames)}) $display("FAIL lat_ack: got upd/ack/frame %h want %h", {update, commit_ack, frame_cnt}, {2'b01, 8'(m_frames)});
    else passed++;
    @(negedge clock);
    total++;
    if ({wr_ready, commit_ack} !== 2'b10) $display("FAIL lat_reopen: got rdy/ack %b want 10", {wr_ready, commit_ack});
    else passed++;
  endtask

  task automatic test_edge_with_commit();
    int bad;
    commit_req = 1'b1; vsync = 1'b0;
    @(negedge clock);
    commit_req = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (update !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL same_cycle_edge: update cycles %0d want 0", bad);
    else passed++;
    vsync = 1'b1;
    @(negedge clock);
    vsync = 1'b0;
    @(negedge clock);
    total++;
    if (update !== 1'b1) $display("FAIL later_edge_update: got %b want 1", update);
    else passed++;
    vsync = 1'b1;
    @(negedge clock);
    m_frames = (m_frames + 1) % 256;
    total++;
    if (frame_cnt !== 8'(m_frames) || commit_ack !== 1'b1) $display("FAIL later_edge_ack: got ack %b frame %0d want 1 %0d", commit_ack, frame_cnt, m_frames);
    else passed++;
    @(negedge clock);
  endtask

  task automatic test_pend_write_hold();
    logic [29:0] d;
    int bad;
    d = 30'($urandom);
    commit_req = 1'b1;
    @(negedge clock);
    commit_req = 1'b0;
    wr_valid = 1'b1; wr_sel = 2'b00; wr_idx = 3'd1; wr_data = d;
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (wr_ready !== 1'b0 || sprites !== exp_spr()) bad++;
    end
    vsync = 1'b0;
    @(negedge clock);
    if (wr_ready !== 1'b0 || sprites !== exp_spr() || update !== 1'b1) bad++;
    vsync = 1'b1;
    @(negedge clock);
    if (wr_ready !== 1'b0 || sprites !== exp_spr() || commit_ack !== 1'b1) bad++;
    m_frames = (m_frames + 1) % 256;
    total++;
    if (bad != 0) $display("FAIL pend_hold: disturbed cycles %0d want 0", bad);
    else passed++;
    @(negedge clock);
    total++;
    if (wr_ready !== 1'b1 || sprites !== exp_spr()) $display("FAIL first_open: rdy %b spr %h want 1 %h", wr_ready, sprites, exp_spr());
    else passed++;
    @(negedge clock);
    wr_valid = 1'b0;
    model_write(2'b00, 1, d);
    total++;
    if (sprites !== exp_spr()) $display("FAIL held_write: got %h want %h", sprites, exp_spr());
    else passed++;
  endtask

  task automatic test_bad_index();
    do_write(2'b01, 3'd7, 30'($urandom));
    total++;
    if (err !== 1'b1 || statics !== exp_stat()) $display("FAIL stat_idx7: err %b stat %h want 1 %h", err, statics, exp_stat());
    else passed++;
    do_write(2'b00, 3'd6, 30'($urandom));
    do_write(2'b11, 3'd0, 30'($urandom));
    total++;
    if ({sprites, statics, offset_y, offset_x} !== {exp_spr(), exp_stat(), m_oy, m_ox}) $display("FAIL bad_writes_inert: got %h want %h", sprites, exp_spr());
    else passed++;
    do_write(2'b10, 3'd0, 30'h3F_ABC_123);
    total++;
    if ({err, offset_y, offset_x} !== {1'b1, 12'hABC, 12'h123}) $display("FAIL err_sticky: got %h want %h", {err, offset_y, offset_x}, {1'b1, 12'hABC, 12'h123});
    else passed++;
  endtask

  task automatic test_reset_mid_commit();
    int bad;
    commit_req = 1'b1;
    @(negedge clock);
    commit_req = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_clear();
    total++;
    if ({update, commit_ack, frame_cnt, err, wr_ready} !== 12'h001 || {sprites, statics, offset_x, offset_y} !== '0)
      $display("FAIL reset_in_pend: ctrl %h want 001", {update, commit_ack, frame_cnt, err, wr_ready});
    else passed++;
    reset = 1'b1;
    @(negedge clock);
    vsync = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clock);
      if (update !== 1'b0 || commit_ack !== 1'b0 || wr_ready !== 1'b1) bad++;
    end
    vsync = 1'b1;
    total++;
    if (bad != 0) $display("FAIL abandon_pend: bad cycles %0d want 0", bad);
    else passed++;
    commit_req = 1'b1;
    @(negedge clock);
    commit_req = 1'b0; vsync = 1'b0;
    @(negedge clock);
    reset = 1'b0; vsync = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (update !== 1'b0 || commit_ack !== 1'b0 || frame_cnt !== 8'd0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL abandon_upd: bad cycles %0d want 0", bad);
    else passed++;
  endtask

  task automatic test_watchdog();
    int n;
    commit_req = 1'b1;
    @(negedge clock);
    commit_req = 1'b0;
`ifdef PPU_SEQ_WATCHDOG_EN
    n = 0;
    while (update !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (n != 50) $display("FAIL wd_latency: update after %0d cycles want 50", n);
    else passed++;
`else
    n = 0;
    repeat (120) begin
      @(negedge clock);
      if (update !== 1'b0) n++;
    end
    total++;
    if (n != 0) $display("FAIL pend_no_wd: update cycles %0d want 0", n);
    else passed++;
    vsync = 1'b0;
    @(negedge clock);
    vsync = 1'b1;
`endif
    @(negedge clock);
    m_frames = (m_frames + 1) % 256;
    total++;
    if (commit_ack !== 1'b1 || frame_cnt !== 8'(m_frames)) $display("FAIL wd_ack: ack %b frame %0d want 1 %0d", commit_ack, frame_cnt, m_frames);
    else passed++;
    @(negedge clock);
  endtask

  task automatic test_frame_wrap();
    int n;
    int start;
    start = m_frames;
    for (int k = 0; k < 256; k++) begin
      commit_req = 1'b1;
      @(negedge clock);
      commit_req = 1'b0; vsync = 1'b0;
      @(negedge clock);
      vsync = 1'b1;
      n = 0;
      while (commit_ack !== 1'b1 && n < 10) begin
        @(negedge clock);
        n++;
      end
      m_frames = (m_frames + 1) % 256;
      total++;
      if (commit_ack !== 1'b1 || frame_cnt !== 8'(m_frames)) $display("FAIL wrap_commit_%0d: ack %b frame %0d want 1 %0d", k, commit_ack, frame_cnt, m_frames);
      else passed++;
      @(negedge clock);
    end
    total++;
    if (frame_cnt !== 8'(start)) $display("FAIL wrap_total: got %0d want %0d", frame_cnt, start);
    else passed++;
  endtask

  initial begin
    vsync = 1'b1; wr_valid = 1'b0; wr_sel = '0; wr_idx = '0; wr_data = '0; commit_req = 1'b0;
    test_reset();
    test_sprite_write();
    test_random_writes();
    test_commit_latency();
    test_edge_with_commit();
    test_pend_write_hold();
    test_bad_index();
    test_reset_mid_commit();
    test_random_writes();
    test_watchdog();
    test_frame_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ppu_update_seq.md
PPU_UPDATE_SEQ -- requirements
Module: ppu_update_seq

Interface
REQ-001 SHALL have parameter NSPR, default 6: number of sprite table entries, each 30 bits.
REQ-002 SHALL have parameter NSTAT, default 6: number of static table entries, each 22 bits.
REQ-003 SHALL have parameter VSYNC_POL, default 0: active level of vsync (0 = active-low).
REQ-004 SHALL have parameter WD_CYCLES, default 2000000: watchdog limit in clock cycles.
REQ-005 clock  in  1  single clock; every flop is on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 vsync  in  1  vsync from the VGA controller, same clock domain.
REQ-008 wr_valid  in  1  game state machine write request.
REQ-009 wr_ready  out  1  write accepted when wr_valid&&wr_ready.
REQ-010 wr_sel  in  2  write target: 00 sprite, 01 static, 10 offset, 11 reserved.
REQ-011 wr_idx  in  3  entry index.
REQ-012 wr_data  in  30  entry data; static uses [21:0]; offset uses {[23:12]=y, [11:0]=x}.
REQ-013 commit_req  in  1  one-cycle pulse marking the frame's table as complete.
REQ-014 commit_ack  out  1  one-cycle pulse when the commit has been presented to the PPU.
REQ-015 sprites  out  30*NSPR  shadow sprite table; entry i at [30i+29:30i].
REQ-016 statics  out  22*NSTAT  shadow static table; entry i at [22i+21:22i].
REQ-017 offset_x, offset_y  out  12 each  shadow viewport offset.
REQ-018 update  out  1  one-cycle load strobe to the PPU.
REQ-019 frame_cnt  out  8  count of completed commits.
REQ-020 err  out  1  sticky: out-of-range index or reserved wr_sel was accepted.

Function
REQ-021 State machine SHALL have four states: OPEN, PEND, UPD, ACK.
REQ-022 OPEN: wr_ready=1; an accepted write updates the addressed shadow entry on that edge.
REQ-023 OPEN: on commit_req go to PEND; a write in the same cycle is accepted first.
REQ-024 PEND: wr_ready=0; commit_req is ignored; shadow outputs are held stable.
REQ-025 PEND exits to UPD on the first registered vsync activation edge (inactive->active) sampled while in PEND.
REQ-026 An edge in the same cycle as commit_req SHALL NOT count.
REQ-027 UPD: update=1 for exactly one cycle, then go to ACK.
REQ-028 ACK: commit_ack=1 for one cycle; frame_cnt increments, wrapping 255->0; then go to OPEN.
REQ-029 Commit latency SHALL be: vsync edge, +1 cycle registered detect, update, next cycle commit_ack.
REQ-030 Writes with idx>=NSPR (sprite), idx>=NSTAT (static) or wr_sel=11 SHALL be accepted, change nothing, and set err.
REQ-031 Static writes SHALL ignore wr_data[29:22]; offset writes SHALL ignore wr_data[29:24].
REQ-032 update and commit_ack SHALL never be high in the same cycle.

Reset
REQ-033 While reset is low: state=OPEN, all shadow entries and offsets =0, update=0, commit_ack=0, frame_cnt=0, err=0, vsync history = inactive level.
REQ-034 Reset mid-PEND or mid-UPD SHALL abandon the commit with no update or ack after release.

Configuration
REQ-035 With PPU_SEQ_WATCHDOG_EN defined: a counter runs in PEND; reaching WD_CYCLES without a vsync edge forces UPD, counter clears on leaving PEND.
REQ-036 Without PPU_SEQ_WATCHDOG_EN: no counter exists; PEND waits indefinitely.

Structure
REQ-037 Shared package SHALL hold the state encoding, the wr_sel codes, SPR_W=30, STAT_W=22, and OFF_W=12.
REQ-038 One sub-module, ppu_edge_det (registered edge detector with polarity parameter), SHALL be used for vsync.

Verification
REQ-039 Sprite write idx 2, data 0x12345678 -> sprites[89:60]=0x12345678 next cycle; other entries unchanged.
REQ-040 commit_req, then vsync edge 100 cycles later -> update high exactly at edge+1, commit_ack at edge+2, frame_cnt=1.
REQ-041 wr_valid held during PEND -> wr_ready=0; shadow is unchanged until ACK; the write is accepted in the first OPEN cycle.
REQ-042 Static write idx 7 -> err=1 and the statics bus is unchanged; err stays 1 until reset.
REQ-043 Reset low during PEND, then release, then vsync edge -> no update; state=OPEN.
REQ-044 With PPU_SEQ_WATCHDOG_EN and WD_CYCLES=50, with no vsync -> update at cycle 50 after entering PEND; 256 commits -> frame_cnt wraps to 0.
